regfile_tagged: RTL

//   Parametrised, multi-read-port register file with a per-register status table (busy bit + producer tag)
//   for the dynamic (Tomasulo-style) pipeline. Issue stage renames a destination register to a tag;
//   the common data bus (CDB) broadcasts tag+data and every waiting register matching the tag captures it.

---
 rtl/regfile_tagged.sv | 100 ++++++++++
 1 files changed

// File: rtl/regfile_tagged.sv
// Register file with per-register busy/tag status for a Tomasulo-style pipeline.
// CDB writeback captures data into waiting registers; reads bypass a same-cycle CDB match.
module regfile_tagged #(
  parameter int DW      = 32,
  parameter int NREG    = 32,
  parameter int AW      = $clog2(NREG),
  parameter int NREAD   = 2,
  parameter int TW      = 4,
  parameter int DBG_REG = 28,
  parameter int CW      = $clog2(NREG + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ena_i,
  input  logic [NREAD*AW-1:0] rd_addr_i,
  output logic [NREAD*DW-1:0] rd_data_o,
  output logic [NREAD-1:0]    rd_busy_o,
  output logic [NREAD*TW-1:0] rd_tag_o,
  input  logic                iss_valid_i,
  input  logic [AW-1:0]       iss_addr_i,
  input  logic [TW-1:0]       iss_tag_i,
  input  logic                wb_valid_i,
  input  logic [TW-1:0]       wb_tag_i,
  input  logic [DW-1:0]       wb_data_i,
  input  logic                flush_i,
  output logic [CW-1:0]       busy_cnt_o,
  output logic [DW-1:0]       dbg_data_o
);

  localparam logic [AW:0] NREG_W = (AW + 1)'(NREG);

  logic [DW-1:0]   data_q [NREG];
  logic [DW-1:0]   data_d [NREG];
  logic [TW-1:0]   tag_q  [NREG];
  logic [TW-1:0]   tag_d  [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [CW-1:0]   cnt_q;

  function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + {{(CW-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Issue wins the status of a register even when the CDB writes its data on the same edge.
  always_comb begin
    data_d    = data_q;
    tag_d     = tag_q;
    busy_d    = busy_q;
    data_d[0] = '0;
    tag_d[0]  = '0;
    busy_d[0] = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      logic wb_hit_s;
      logic iss_hit_s;
      wb_hit_s  = ena_i && wb_valid_i && busy_q[r] && (tag_q[r] == wb_tag_i);
      iss_hit_s = ena_i && iss_valid_i && !flush_i && (iss_addr_i == AW'(r));
      data_d[r] = wb_hit_s  ? wb_data_i : data_q[r];
      tag_d[r]  = iss_hit_s ? iss_tag_i : tag_q[r];
      busy_d[r] = iss_hit_s || (busy_q[r] && !wb_hit_s && !(ena_i && flush_i));
    end
  end

  // State registers; the busy count tracks the busy vector it is loaded alongside.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NREG; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
      cnt_q  <= popcount(busy_d);
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0] a_s;
    logic          valid_s;
    logic          byp_s;
    assign a_s     = rd_addr_i[p*AW +: AW];
    assign valid_s = ena_i && (a_s != '0) && ({1'b0, a_s} < NREG_W);
    assign byp_s   = valid_s && wb_valid_i && busy_q[a_s] && (tag_q[a_s] == wb_tag_i);
    assign rd_data_o[p*DW +: DW] = !valid_s ? '0 : (byp_s ? wb_data_i : data_q[a_s]);
    assign rd_busy_o[p]          = valid_s && busy_q[a_s] && !byp_s;
    assign rd_tag_o[p*TW +: TW]  = valid_s ? tag_q[a_s] : '0;
  end

  assign busy_cnt_o = cnt_q;
  assign dbg_data_o = data_q[DBG_REG];

endmodule
